// File: rtl/if_prefetch_if.sv
// -----------------------------------------------------------------------------
// if_prefetch_if
// Purpose : bundles the two handshakes of the prefetching IF stage.
//   i-cache side : mc_inst_enable_o / mc_inst_addr_o (request),
//                  mc_inst_enable_i / mc_inst_data_i (one-cycle response pulse)
//   IF/ID side   : inst_valid_o / inst_o / pc_o (queue head),
//                  inst_ready_i (consumer accept), if_stall_req_o (= !inst_valid_o)
// Modports: master = the fetch stage, slave = i-cache plus IF/ID consumer.
//
// Handshake semantics (IF/ID side): a word transfers on every rising edge
// where inst_valid_o && inst_ready_i. inst_valid_o never depends on
// inst_ready_i. inst_o/pc_o are zero whenever inst_valid_o is low.
// i-cache side: one request outstanding at most; the address is stable while
// mc_inst_enable_o is high; mc_inst_enable_i pulses for one cycle with data.
// -----------------------------------------------------------------------------
interface if_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) ();
  logic              mc_inst_enable_o;
  logic [ADDR_W-1:0] mc_inst_addr_o;
  logic              mc_inst_enable_i;
  logic [INST_W-1:0] mc_inst_data_i;
  logic              inst_valid_o;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              inst_ready_i;
  logic              if_stall_req_o;

  modport master (
    output mc_inst_enable_o, mc_inst_addr_o,
    input  mc_inst_enable_i, mc_inst_data_i,
    output inst_valid_o, inst_o, pc_o, if_stall_req_o,
    input  inst_ready_i
  );

  modport slave (
    input  mc_inst_enable_o, mc_inst_addr_o,
    output mc_inst_enable_i, mc_inst_data_i,
    input  inst_valid_o, inst_o, pc_o, if_stall_req_o,
    output inst_ready_i
  );
endinterface

// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
// Purpose : instruction fetch stage with a DEPTH-entry prefetch queue. Owns the
//           fetch PC, issues sequential i-cache requests (one outstanding),
//           buffers {pc, inst} pairs and presents the head to IF/ID. A redirect
//           flushes the queue and discards the in-flight response of the old
//           path.
// Ports   :
//   clk_in       clock, rising edge
//   rst_in       synchronous active-high reset
//   jump_i       redirect pulse from EX
//   jump_addr_i  redirect target (low 2 bits ignored)
//   bus          if_prefetch_if.master (i-cache and IF/ID handshakes)
//   dbg_state_o  current FSM state (0 IDLE, 1 WAIT, 2 DISCARD)
// Options : define IF_BYPASS_EN to forward a response straight to the IF/ID
//           outputs in the response cycle when the queue is empty.
// -----------------------------------------------------------------------------
module if_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  if_prefetch_if.master     bus,
  output logic [1:0]        dbg_state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_next;
  logic [ADDR_W-1:0] r_req_addr, w_req_addr_next;
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count, w_count_next;
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];

  logic              w_head_valid;
  logic              w_resp;
  logic              w_bypass;
  logic              w_bypass_take;
  logic              w_enq;
  logic              w_deq;
  logic              w_valid;
  logic [ADDR_W-1:0] w_jump_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_jump_lsb_unused;

  assign w_jump_target     = {jump_addr_i[ADDR_W-1:2], 2'b00};
  assign w_jump_lsb_unused = ^jump_addr_i[1:0];
  assign w_pc_inc          = r_fetch_pc + ADDR_W'(4);
  assign w_head_valid      = (r_count != '0);
  assign w_resp            = bus.mc_inst_enable_i;

`ifdef IF_BYPASS_EN
  // Empty queue + response on the live path: present the word this cycle.
  assign w_bypass = (r_state == S_WAIT) && w_resp && !jump_i && !w_head_valid;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_bypass_take = w_bypass && bus.inst_ready_i;

  // A response is only kept when it belongs to the live path (WAIT, no
  // redirect this cycle) and was not already consumed through the bypass.
  assign w_enq        = (r_state == S_WAIT) && w_resp && !jump_i && !w_bypass_take;
  assign w_deq        = w_head_valid && bus.inst_ready_i && !jump_i;
  assign w_count_next = r_count + CW'(w_enq) - CW'(w_deq);

  // Next-state, fetch PC and request address.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req_addr_next = r_req_addr;
    case (r_state)
      S_IDLE: begin
        if (jump_i) begin
          w_fetch_pc_next = w_jump_target;
        end else if (w_count_next < DEPTH_C) begin
          w_state_next    = S_WAIT;
          w_req_addr_next = r_fetch_pc;
        end
      end
      S_WAIT: begin
        if (jump_i) begin
          w_fetch_pc_next = w_jump_target;
          // Address stays put in DISCARD so the cache sees a stable request.
          w_state_next    = w_resp ? S_IDLE : S_DISCARD;
        end else if (w_resp) begin
          w_fetch_pc_next = w_pc_inc;
          if (w_count_next < DEPTH_C) begin
            w_req_addr_next = w_pc_inc;   // back-to-back, no bubble
          end else begin
            w_state_next    = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (jump_i) begin
          w_fetch_pc_next = w_jump_target;
        end
        if (w_resp) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req_addr <= w_req_addr_next;
    end
  end

  // Queue bookkeeping; a redirect wins over any enqueue/dequeue that cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in || jump_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PW'(1);
      if (w_deq) r_rptr <= r_rptr + PW'(1);
      r_count <= w_count_next;
    end
  end

  // Storage has no reset; entries are only read when counted valid.
  always_ff @(posedge clk_in) begin
    if (w_enq && !rst_in) begin
      r_pc_mem[r_wptr]   <= r_req_addr;
      r_inst_mem[r_wptr] <= bus.mc_inst_data_i;
    end
  end

  assign w_valid              = w_head_valid || w_bypass;
  assign bus.inst_valid_o     = w_valid;
  assign bus.inst_o           = w_head_valid ? r_inst_mem[r_rptr] :
                                (w_bypass ? bus.mc_inst_data_i : '0);
  assign bus.pc_o             = w_head_valid ? r_pc_mem[r_rptr] :
                                (w_bypass ? r_req_addr : '0);
  assign bus.if_stall_req_o   = !w_valid;
  assign bus.mc_inst_enable_o = (r_state != S_IDLE);
  assign bus.mc_inst_addr_o   = r_req_addr;
  assign dbg_state_o          = r_state;

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
Parametrised successor to the single-shot IF stage. It owns the fetch PC and issues sequential instruction requests to the i-cache, one outstanding at a time. Returned words go into a DEPTH-entry prefetch queue that feeds IF/ID through a valid/ready handshake. A redirect from EX (jump/branch) flushes the queue, and the block discards any in-flight response that belongs to the old path.

Parameters:
ADDR_W, 32, fetch address width
INST_W, 32, instruction word width
DEPTH, 4, prefetch queue entries; power of two, 2..16
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk_in  input  1  system clock; all state updates on rising edge
rst_in  input  1  synchronous reset, active-high
jump_i  input  1  redirect request from EX, one-cycle pulse
jump_addr_i  input  ADDR_W  redirect target; low 2 bits ignored (treated as 0)
mc_inst_enable_o  output  1  request to i-cache; held high until response
mc_inst_addr_o  output  ADDR_W  request address; stable while mc_inst_enable_o=1
mc_inst_enable_i  input  1  i-cache response valid, one-cycle pulse
mc_inst_data_i  input  INST_W  response word, valid with mc_inst_enable_i
inst_valid_o  output  1  queue head valid toward IF/ID
inst_o  output  INST_W  head instruction (0 when inst_valid_o=0)
pc_o  output  ADDR_W  head PC (0 when inst_valid_o=0)
inst_ready_i  input  1  IF/ID accepts head this cycle (deasserted while stall_i[1] is set upstream)
if_stall_req_o  output  1  equals !inst_valid_o, feeds stall controller

Behaviour:
- Reset (rst_in=1 at edge): state=IDLE, fetch_pc=RESET_PC, queue empty.
- Reset values: mc_inst_enable_o=0, mc_inst_addr_o=0, inst_valid_o=0, inst_o=0, pc_o=0, if_stall_req_o=1.
- Reset mid-request abandons the request. The i-cache must tolerate enable dropping.
- Queue: circular buffer. Each entry is {pc, inst}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Dequeue when inst_valid_o && inst_ready_i. Enqueue on an accepted response.
- Space check: count_next = count + enq - deq.
- States:
  IDLE: no request. If !jump_i and count_next < DEPTH, go to WAIT with mc_inst_addr_o=fetch_pc.
  WAIT: mc_inst_enable_o=1.
    - On mc_inst_enable_i: enqueue {mc_inst_addr_o, data} and set fetch_pc += 4 (wraps at 2^ADDR_W).
    - If count_next < DEPTH after that enqueue, stay in WAIT with mc_inst_addr_o = new fetch_pc. This gives back-to-back requests with no bubble. Otherwise go to IDLE.
  DISCARD: mc_inst_enable_o=1 with the old address held. On mc_inst_enable_i, drop the data and go to IDLE.
- Redirect (jump_i=1):
  - Flush the queue (count=0, pointers=0); any dequeue in the same cycle is ignored.
  - Set fetch_pc = {jump_addr_i[ADDR_W-1:2], 2'b00}.
  - From IDLE: stay in IDLE; the next cycle issues a request to the target.
  - From WAIT without a response that cycle: go to DISCARD.
  - From WAIT with a response that same cycle: drop the response and go to IDLE.
  - From DISCARD: stay in DISCARD with the new fetch_pc. If the response arrives that same cycle, drop it and go to IDLE.
- Latency: a response is visible on inst_valid_o the cycle after mc_inst_enable_i (1 cycle). The first request after reset asserts in cycle 1.
- Full: no request is issued while count_next == DEPTH. The one-outstanding rule plus the space check guarantees no overflow.
- Empty: inst_valid_o=0, and inst_o/pc_o are driven to 0.
- Response with no outstanding request (IDLE): ignored.

Optional Feature:
IF_BYPASS_EN
- Defined: when the queue is empty, state=WAIT and mc_inst_enable_i=1 with no jump_i, the response is driven combinationally onto inst_o/pc_o with inst_valid_o=1 in the same cycle. If inst_ready_i=1, the word is consumed and not enqueued; otherwise it is enqueued as normal. Latency is 0 cycles.
- Undefined: latency is always 1 cycle, and inst_valid_o depends only on registered state.

Test Plan:
1. Reset then cache responding 2 cycles after each request, inst_ready_i=1 -> addresses 0x0,0x4,0x8 requested in order; pc_o/inst_o sequence matches the returned words; no request gap after a response.
2. inst_ready_i=0, DEPTH=4 -> exactly 4 responses enqueued, mc_inst_enable_o=0 after the 4th. Set ready=1 -> the 4 words drain in order, then fetch resumes at 0x10.
3. jump_i with jump_addr_i=0x103 while in WAIT at addr 0x8 -> queue flushed, inst_valid_o=0 next cycle; the 0x8 response is dropped; the next request is at 0x100.
4. jump_i in the same cycle as a response and a dequeue -> response and dequeue both dropped; next request at the target one cycle later; count=0.
5. rst_in asserted mid-WAIT with a queue of 2 -> next cycle all outputs at reset values; the first request after reset is to RESET_PC.
6. With IF_BYPASS_EN, empty queue, response 0xDEADBEEF at 0x0, ready=1 -> inst_valid_o=1 and inst_o=0xDEADBEEF in the response cycle; queue stays empty.
